// File: rtl/sprite_motion_pkg.sv
// sprite_motion_pkg: shared FSM state and per-sprite register record for sprite_motion_engine.
package sprite_motion_pkg;
  localparam int SM_POS_WIDTH = 8;
  localparam int SM_STEP_WIDTH = 3;
  localparam int SM_DIV_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} motion_state_t;
  typedef struct packed {
    logic [SM_POS_WIDTH-1:0] x;
    logic [SM_POS_WIDTH-1:0] y;
    logic dir_x;
    logic dir_y;
    logic [SM_STEP_WIDTH-1:0] step_x;
    logic [SM_STEP_WIDTH-1:0] step_y;
    logic [SM_DIV_WIDTH-1:0] div;
    logic [SM_DIV_WIDTH-1:0] div_cnt;
    logic wrap;
  } sprite_state_t;
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: combinational single-axis move with bounce or wrap at the window edge.
module sprite_axis_step #(
  parameter int POS_WIDTH = 8,
  parameter int STEP_WIDTH = 3
) (
  input  logic [POS_WIDTH-1:0]  pos,
  input  logic                  dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [POS_WIDTH-1:0]  max,
  input  logic                  wrap,
  output logic [POS_WIDTH-1:0]  next_pos,
  output logic                  next_dir,
  output logic                  bounce
);
  localparam int W1 = POS_WIDTH + 1;
  logic [POS_WIDTH:0] p, s, m, m1, sum;
  logic [POS_WIDTH-1:0] diff, wrapped;
  logic hit, moving;
  // one extra bit keeps pos+step and max+1 from overflowing
  always_comb begin
    p = {1'b0, pos};
    s = W1'(step);
    m = {1'b0, max};
    m1 = m + W1'(1);
    sum = p + s;
    diff = pos - POS_WIDTH'(step);
    moving = step != '0;
    hit = dir ? (wrap ? p < s : p <= s) : (wrap ? sum > m : sum >= m);
    wrapped = dir ? POS_WIDTH'(p + m1 - s) : POS_WIDTH'(sum - m1);
    next_pos = !moving ? pos
             : hit ? (wrap ? wrapped : (dir ? '0 : max))
             : (dir ? diff : sum[POS_WIDTH-1:0]);
    bounce = moving && hit && !wrap;
    next_dir = bounce ? !dir : dir;
  end
endmodule

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: per-frame sweep updating position/direction of NUM_SPRITES sprites, one per cycle.
module sprite_motion_engine
  import sprite_motion_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int POS_WIDTH = SM_POS_WIDTH,
  parameter int AREA_WIDTH = 160,
  parameter int AREA_HEIGHT = 120,
  parameter int SPRITE_WIDTH = 16,
  parameter int SPRITE_HEIGHT = 16,
  parameter int STEP_WIDTH = SM_STEP_WIDTH,
  parameter int DIV_WIDTH = SM_DIV_WIDTH,
  localparam int IDX_WIDTH = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable_movement,
  input  logic                            next_frame,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [IDX_WIDTH-1:0]            cfg_index,
  input  logic [POS_WIDTH-1:0]            cfg_x,
  input  logic [POS_WIDTH-1:0]            cfg_y,
  input  logic [STEP_WIDTH-1:0]           cfg_step_x,
  input  logic [STEP_WIDTH-1:0]           cfg_step_y,
  input  logic [DIV_WIDTH-1:0]            cfg_div,
  input  logic                            cfg_wrap,
  output logic [NUM_SPRITES*POS_WIDTH-1:0] sprite_x,
  output logic [NUM_SPRITES*POS_WIDTH-1:0] sprite_y,
  output logic [NUM_SPRITES-1:0]          bounce_x,
  output logic [NUM_SPRITES-1:0]          bounce_y,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);
  localparam logic [POS_WIDTH-1:0] MAX_X = POS_WIDTH'(AREA_WIDTH - SPRITE_WIDTH);
  localparam logic [POS_WIDTH-1:0] MAX_Y = POS_WIDTH'(AREA_HEIGHT - SPRITE_HEIGHT);
  localparam sprite_state_t SPRITE_RST = '{x: '0, y: '0, dir_x: 1'b0, dir_y: 1'b0,
    step_x: SM_STEP_WIDTH'(1), step_y: SM_STEP_WIDTH'(1), div: SM_DIV_WIDTH'(1), div_cnt: '0, wrap: 1'b0};
  motion_state_t state;
  logic [IDX_WIDTH-1:0] idx;
  sprite_state_t spr [NUM_SPRITES];
  sprite_state_t cur, upd, cfg_rec;
  logic [POS_WIDTH-1:0] nx, ny;
  logic ndx, ndy, bx, by, move, last, cfg_we;
  assign busy = state != IDLE;
  assign cfg_ready = !busy;
  assign frame_done = state == DONE;
  assign cur = spr[idx];
  assign move = cur.div_cnt == '0;
  assign last = idx == IDX_WIDTH'(NUM_SPRITES - 1);
  assign cfg_we = cfg_valid && cfg_ready && int'(cfg_index) < NUM_SPRITES;
  sprite_axis_step #(.POS_WIDTH(POS_WIDTH), .STEP_WIDTH(STEP_WIDTH)) u_axis_x (
    .pos(cur.x), .dir(cur.dir_x), .step(cur.step_x), .max(MAX_X), .wrap(cur.wrap),
    .next_pos(nx), .next_dir(ndx), .bounce(bx)
  );
  sprite_axis_step #(.POS_WIDTH(POS_WIDTH), .STEP_WIDTH(STEP_WIDTH)) u_axis_y (
    .pos(cur.y), .dir(cur.dir_y), .step(cur.step_y), .max(MAX_Y), .wrap(cur.wrap),
    .next_pos(ny), .next_dir(ndy), .bounce(by)
  );
  always_comb begin
    upd = cur;
    upd.div_cnt = move ? cur.div : cur.div_cnt - 1'b1;
    upd.x = move ? nx : cur.x;
    upd.y = move ? ny : cur.y;
    upd.dir_x = move ? ndx : cur.dir_x;
    upd.dir_y = move ? ndy : cur.dir_y;
    cfg_rec = SPRITE_RST;
    cfg_rec.x = cfg_x > MAX_X ? MAX_X : cfg_x;
    cfg_rec.y = cfg_y > MAX_Y ? MAX_Y : cfg_y;
    cfg_rec.step_x = cfg_step_x;
    cfg_rec.step_y = cfg_step_y;
    cfg_rec.div = cfg_div;
    cfg_rec.wrap = cfg_wrap;
  end
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_out
    assign sprite_x[i*POS_WIDTH +: POS_WIDTH] = spr[i].x;
    assign sprite_y[i*POS_WIDTH +: POS_WIDTH] = spr[i].y;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      overrun <= 1'b0;
      bounce_x <= '0;
      bounce_y <= '0;
      for (int k = 0; k < NUM_SPRITES; k++) spr[k] <= SPRITE_RST;
    end else begin
      overrun <= next_frame && busy;
      bounce_x <= '0;
      bounce_y <= '0;
      if (cfg_we) spr[cfg_index] <= cfg_rec;
      case (state)
        IDLE: begin
          idx <= '0;
          if (next_frame && enable_movement) state <= UPDATE;
        end
        UPDATE: begin
          spr[idx] <= upd;
          bounce_x[idx] <= bx && move;
          bounce_y[idx] <= by && move;
          idx <= idx + 1'b1;
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine: directed and randomized checks against a frame-level behavioural model.
module tb_sprite_motion_engine;
  localparam int N = 4, PW = 8, MAXX = 144, MAXY = 104;
  logic clk = 0, reset = 1, enable_movement = 0, next_frame = 0, cfg_valid = 0, cfg_wrap = 0;
  logic cfg_ready, busy, frame_done, overrun;
  logic [1:0] cfg_index = 0;
  logic [7:0] cfg_x = 0, cfg_y = 0;
  logic [2:0] cfg_step_x = 0, cfg_step_y = 0;
  logic [3:0] cfg_div = 0;
  logic [N*PW-1:0] sprite_x, sprite_y, ex, ey;
  logic [N-1:0] bounce_x, bounce_y, ebx, eby, fbx, fby;
  logic eov;
  int checks = 0, errors = 0;
  int px[N], py[N], ddx[N], ddy[N], stx[N], sty[N], dv[N], dc[N], wr[N];
  int shx[N], shy[N], pnx[N], pny[N], pbx[N], pby[N];
  int cyc = 0, sweep_t = -100;
  always #5 clk = ~clk;

  sprite_motion_engine dut (
    .clk(clk), .reset(reset), .enable_movement(enable_movement), .next_frame(next_frame),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y), .cfg_div(cfg_div), .cfg_wrap(cfg_wrap),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .bounce_x(bounce_x), .bounce_y(bounce_y),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_sweep(int t);
    return t >= sweep_t + 1 && t <= sweep_t + N + 1;
  endfunction

  task automatic axis(input int pos, input int dir, input int step, input int lim, input int wrp,
                      output int np, output int nd, output int b);
    np = pos; nd = dir; b = 0;
    if (step == 0) return;
    if (wrp != 0) np = ((pos + (dir != 0 ? -step : step)) % (lim + 1) + lim + 1) % (lim + 1);
    else if (dir == 0) begin
      if (pos + step >= lim) begin np = lim; nd = 1; b = 1; end else np = pos + step;
    end else begin
      if (pos <= step) begin np = 0; nd = 0; b = 1; end else np = pos - step;
    end
  endtask

  // whole-frame update computed at acceptance; results revealed one sprite per cycle
  task automatic sweep_model();
    int nx, nd, b;
    for (int i = 0; i < N; i++) begin
      pbx[i] = 0; pby[i] = 0;
      if (dc[i] != 0) dc[i]--;
      else begin
        dc[i] = dv[i];
        axis(px[i], ddx[i], stx[i], MAXX, wr[i], nx, nd, b); px[i] = nx; ddx[i] = nd; pbx[i] = b;
        axis(py[i], ddy[i], sty[i], MAXY, wr[i], nx, nd, b); py[i] = nx; ddy[i] = nd; pby[i] = b;
      end
      pnx[i] = px[i]; pny[i] = py[i];
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        px[i] = 0; py[i] = 0; ddx[i] = 0; ddy[i] = 0; stx[i] = 1; sty[i] = 1;
        dv[i] = 1; dc[i] = 0; wr[i] = 0; shx[i] = 0; shy[i] = 0;
      end
      sweep_t = -100; ebx = '0; eby = '0; eov = 1'b0;
    end else begin
      eov = next_frame && in_sweep(cyc);
      ebx = '0; eby = '0;
      for (int i = 0; i < N; i++)
        if (cyc == sweep_t + 1 + i) begin
          shx[i] = pnx[i]; shy[i] = pny[i]; ebx[i] = pbx[i][0]; eby[i] = pby[i][0];
        end
      if (!in_sweep(cyc)) begin
        if (cfg_valid && int'(cfg_index) < N) begin
          px[cfg_index] = cfg_x > MAXX ? MAXX : int'(cfg_x);
          py[cfg_index] = cfg_y > MAXY ? MAXY : int'(cfg_y);
          ddx[cfg_index] = 0; ddy[cfg_index] = 0; dc[cfg_index] = 0;
          stx[cfg_index] = cfg_step_x; sty[cfg_index] = cfg_step_y;
          dv[cfg_index] = cfg_div; wr[cfg_index] = cfg_wrap;
          shx[cfg_index] = px[cfg_index]; shy[cfg_index] = py[cfg_index];
        end
        if (next_frame && enable_movement) begin
          sweep_t = cyc;
          sweep_model();
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) if (!reset) begin
    for (int i = 0; i < N; i++) begin
      ex[i*PW +: PW] = PW'(shx[i]);
      ey[i*PW +: PW] = PW'(shy[i]);
    end
    chk("busy", busy, in_sweep(cyc));
    chk("cfg_ready", cfg_ready, !in_sweep(cyc));
    chk("frame_done", frame_done, cyc == sweep_t + N + 1);
    chk("overrun", overrun, eov);
    chk("bounce_x", bounce_x, ebx);
    chk("bounce_y", bounce_y, eby);
    chk("sprite_x", sprite_x, ex);
    chk("sprite_y", sprite_y, ey);
  end

  task automatic frame();
    @(negedge clk); next_frame = 1;
    fbx = '0; fby = '0;
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk); next_frame = 0;
      fbx |= bounce_x; fby |= bounce_y;
      if (k == N) chk("fd_early", frame_done, 0);
      if (k == N + 1) chk("fd_t5", frame_done, 1);
    end
  endtask

  task automatic cfg(input int i, input int x, input int y, input int sx, input int sy, input int d, input int w);
    @(negedge clk);
    cfg_valid = 1; cfg_index = 2'(i); cfg_x = 8'(x); cfg_y = 8'(y);
    cfg_step_x = 3'(sx); cfg_step_y = 3'(sy); cfg_div = 4'(d); cfg_wrap = 1'(w);
    @(negedge clk); cfg_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int exp_div[7];
    exp_div = '{1, 1, 1, 2, 2, 2, 3};
    repeat (3) @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_x", sprite_x, 0);
    enable_movement = 1;
    frame();
    chk("def_f1_x", sprite_x, 32'h01010101);
    chk("def_f1_y", sprite_y, 32'h01010101);
    frame();
    chk("def_f2_x", sprite_x, 32'h01010101);
    cfg(0, 142, 0, 3, 0, 0, 0);
    frame();
    chk("bnc_f1_x", sprite_x[7:0], 144);
    chk("bnc_pulse", fbx[0], 1);
    frame();
    chk("bnc_f2_x", sprite_x[7:0], 141);
    chk("bnc_f2_nopulse", fbx[0], 0);
    cfg(1, 143, 103, 3, 3, 0, 1);
    frame();
    chk("wrap_x", sprite_x[15:8], 1);
    chk("wrap_y", sprite_y[15:8], 1);
    chk("wrap_nopulse", {fbx[1], fby[1]}, 0);
    cfg(2, 0, 0, 1, 1, 2, 0);
    for (int f = 0; f < 7; f++) begin
      frame();
      chk("div_x", sprite_x[23:16], exp_div[f]);
    end
    cfg(3, 255, 255, 0, 0, 0, 0);
    chk("clamp_x", sprite_x[31:24], MAXX);
    chk("clamp_y", sprite_y[31:24], MAXY);
    @(negedge clk); next_frame = 1;
    @(negedge clk); next_frame = 0;
    @(negedge clk); next_frame = 1;
    cfg_valid = 1; cfg_index = 3; cfg_x = 50; cfg_y = 60; cfg_step_x = 0; cfg_step_y = 0; cfg_div = 0; cfg_wrap = 0;
    chk("ho_ready_t2", cfg_ready, 0);
    @(negedge clk); next_frame = 0;
    chk("overrun_t3", overrun, 1);
    repeat (3) @(negedge clk);
    chk("ho_ready_t6", cfg_ready, 1);
    @(negedge clk); cfg_valid = 0;
    chk("ho_x", sprite_x[31:24], 50);
    chk("single_sweep", busy, 0);
    @(negedge clk); next_frame = 1;
    @(negedge clk); next_frame = 0;
    @(negedge clk); #2 reset = 1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", cfg_ready, 1);
    chk("ar_x", sprite_x, 0);
    chk("ar_y", sprite_y, 0);
    chk("ar_bounce", {bounce_x, bounce_y, frame_done, overrun}, 0);
    @(negedge clk); #2 reset = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      next_frame = $urandom_range(0, 7) == 0;
      enable_movement = $urandom_range(0, 3) != 0;
      cfg_valid = $urandom_range(0, 4) == 0;
      cfg_index = 2'($urandom);
      cfg_x = 8'($urandom);
      cfg_y = 8'($urandom);
      cfg_step_x = 3'($urandom);
      cfg_step_y = 3'($urandom);
      cfg_div = 4'($urandom_range(0, 3));
      cfg_wrap = 1'($urandom);
    end
    @(negedge clk);
    next_frame = 0; cfg_valid = 0;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_motion_engine.md
# sprite_motion_engine

Parametrised multi-sprite motion controller that replaces single-sprite bounce logic. It holds position, direction, per-axis step size, speed divider and edge mode (bounce or wrap) for `NUM_SPRITES` sprites. On each frame boundary it sweeps all sprites one per cycle through a small FSM. It sits between the frame timing generator and the sprite renderer; positions are in scaled-down pixel coordinates.

## Interface
- `NUM_SPRITES`, 4, number of sprites (≥1)
- `POS_WIDTH`, 8, position width per axis
- `AREA_WIDTH`, 160, scaled window width
- `AREA_HEIGHT`, 120, scaled window height
- `SPRITE_WIDTH`, 16, sprite width (< `AREA_WIDTH`)
- `SPRITE_HEIGHT`, 16, sprite height (< `AREA_HEIGHT`)
- `STEP_WIDTH`, 3, per-axis step width
- `DIV_WIDTH`, 4, frame divider width
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1, clock
- `reset` in 1, asynchronous, active-high
- `enable_movement` in 1, gates sweep start
- `next_frame` in 1, frame-completed pulse
- `cfg_valid` in 1, config write request
- `cfg_ready` out 1, equals !`busy`
- `cfg_index` in max(1,$clog2(`NUM_SPRITES`)), target sprite
- `cfg_x`, `cfg_y` in `POS_WIDTH` each, start position
- `cfg_step_x`, `cfg_step_y` in `STEP_WIDTH` each, pixels per move
- `cfg_div` in `DIV_WIDTH`, frames skipped between moves
- `cfg_wrap` in 1, 1 = wrap, 0 = bounce
- `sprite_x`, `sprite_y` out `NUM_SPRITES*POS_WIDTH` each, packed positions; sprite i at [i*`POS_WIDTH` +: `POS_WIDTH`]
- `bounce_x`, `bounce_y` out `NUM_SPRITES` each, one-cycle edge-hit pulses
- `busy` out 1, sweep in progress
- `frame_done` out 1, one-cycle pulse at sweep end
- `overrun` out 1, one-cycle pulse when `next_frame` arrives while busy

## Operation
- Per-sprite registers: x, y, dir_x, dir_y (0 = increasing), step_x, step_y, div, div_cnt, wrap.
- Reset values: all positions 0, dirs 0, steps 1, div 1, div_cnt 0, wrap 0. FSM in IDLE. All outputs 0 except `cfg_ready`=1. Reset mid-sweep aborts the sweep immediately.
- FSM states:
  - IDLE → UPDATE on `next_frame && enable_movement`; index := 0.
  - UPDATE processes sprite[index] and increments index. After index `NUM_SPRITES`-1, go to DONE.
  - DONE → IDLE unconditionally.
- `next_frame` with `enable_movement`=0 in IDLE: no sweep, no `frame_done`.
- Deasserting `enable_movement` mid-sweep: the sweep completes.
- `next_frame` in UPDATE/DONE: ignored for motion; `overrun` pulses.
- Per-sprite update:
  - If div_cnt≠0: div_cnt−1, no motion.
  - Else: div_cnt := div, both axes step.
- Axis step, with max = AREA − SPRITE and all arithmetic at `POS_WIDTH`+1 bits:
  - Bounce, dir 0: if pos+step ≥ max → pos := max, dir := 1, bounce pulse; else pos += step.
  - Bounce, dir 1: if pos ≤ step → pos := 0, dir := 0, bounce pulse; else pos −= step.
  - Wrap, dir 0: if pos+step > max → pos := pos+step−(max+1); else pos += step. No pulse, dir unchanged.
  - Wrap, dir 1: if pos < step → pos := pos+(max+1)−step; else pos −= step.
  - Step 0: position and dir unchanged, no pulse.
- Config write (`cfg_valid && cfg_ready`):
  - Loads x := min(`cfg_x`, max_x) and y := min(`cfg_y`, max_y), plus steps, div and wrap.
  - Clears dirs and div_cnt.
  - `cfg_index` ≥ `NUM_SPRITES`: write dropped.
- Config write and `next_frame` in the same IDLE cycle: both accepted. The written values are used by the sweep.

## Timing
- `next_frame` sampled at cycle T (IDLE):
  - `busy`=1 during T+1..T+N+1.
  - Sprite i is evaluated in cycle T+1+i; its new position and bounce pulse are visible in cycle T+2+i.
  - `frame_done` is high in cycle T+N+1 (DONE). IDLE and `cfg_ready`=1 resume at T+N+2.
- `overrun` registered: high the cycle after the offending `next_frame`.
- Outputs are registers only; no combinational input→output paths except `cfg_ready` = !`busy`, which comes from the state register.

## Structure
- Package `sprite_motion_pkg`:
  - FSM state enum `motion_state_t` (IDLE, UPDATE, DONE).
  - Struct `sprite_state_t` holding the per-sprite registers.
- Sub-module `sprite_axis_step`: combinational single-axis update.
  - Inputs: pos, dir, step, max, wrap.
  - Outputs: next pos, next dir, bounce.
  - Instantiated twice, x and y, on the sprite selected by index.

## Test plan
- Reset, then 2 frames with defaults (N=4) → every sprite at (1,1) after frame 1 and still (1,1) after frame 2. `frame_done` at T+5 each time.
- Bounce: sprite 0 configured x=142, step_x=3, div=0 → frame 1: x=144, `bounce_x[0]` pulse, dir 1. Frame 2: x=141.
- Wrap: x=143, step 3, wrap, dir 0 → x=1. Wrap dir 1 from x=1, step 3 → x=143. No bounce pulses.
- Divider: div=2, x=0, step 1 → x changes only on frames 1, 4, 7 (values 1, 2, 3).
- Overrun/handshake: `next_frame` at T and T+2 → `overrun` at T+3, single sweep. `cfg_valid` at T+2 is held off (`cfg_ready`=0) and accepted at T+6.
- Async `reset` asserted at T+2 mid-sweep → all outputs 0 immediately, `cfg_ready`=1, positions 0.
